// File: rtl/anton_neopixel_pixel_shifter.sv
// NeoPixel pixel shifter: prefetches one GRB pixel from the byte buffer and serialises it MSB first.
// Optional build macro ANTON_NEOPIXEL_UNDERRUN_COUNT_EN adds the saturating underrunCount output.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 63
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module anton_neopixel_pixel_shifter #(
  parameter int unsigned  BUFFER_END  = `BUFFER_END_DEFAULT,
  localparam int unsigned BUFFER_BITS = `CLOG2(BUFFER_END + 1)
) (
  input  logic                   clk6_4mhz,
  input  logic                   rstn,
  input  logic                   streamOutput,
  input  logic                   streamReset,
  input  logic                   streamBitOf,
  input  logic                   streamPixelOf,
  input  logic                   regCtrl32bit,
  input  logic [2:0]             bitPatternIndex,
  input  logic [4:0]             pixelBitIndex,
  input  logic [BUFFER_BITS-1:0] pixelIndex,
  input  logic [BUFFER_BITS-1:0] pixelIndexMax,
  output logic                   rdReq,
  output logic [BUFFER_BITS-1:0] rdAddr,
  input  logic [7:0]             rdData,
  input  logic                   rdValid,
  output logic                   neopixelOut,
  output logic                   underrun
`ifdef ANTON_NEOPIXEL_UNDERRUN_COUNT_EN
  ,
  output logic [7:0]             underrunCount
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic                   mode32_q, mode32_d;
  logic [2:0][7:0]        bytes_q, bytes_d;
  logic [23:0]            next_pixel_q, next_pixel_d;
  logic                   next_valid_q, next_valid_d;
  logic [23:0]            cur_pixel_q, cur_pixel_d;
  logic                   rd_req_q, rd_req_d;
  logic [BUFFER_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                   neo_q, neo_d;
  logic                   underrun_q, underrun_d;

  // Frame-level strobes are not needed here; the per-bit indices carry all timing.
  logic unused_strobes;
  assign unused_strobes = ^{streamReset, streamBitOf, streamPixelOf};

  logic [23:0]            fetched_c;
  logic [2:0]             r3, g3;
  logic [1:0]             b2;
  logic                   done_c, load_c, have_c, bit_c;
  logic [23:0]            src_c;
  logic [4:0]             bit_idx;
  logic [BUFFER_BITS-1:0] idx_eq, succ_addr;

  // Assemble the completed fetch into GRB, expanding RGB332 by bit replication.
  always_comb begin
    r3 = bytes_q[0][7:5];
    g3 = bytes_q[0][4:2];
    b2 = bytes_q[0][1:0];
    if (mode32_q) fetched_c = {bytes_q[0], bytes_q[1], bytes_q[2]};
    else          fetched_c = {g3, g3, g3[2:1], r3, r3, r3[2:1], b2, b2, b2, b2};
  end

  // Address of the pixel after the one being shown; 32-bit pixels occupy 4-byte slots.
  always_comb begin
    idx_eq    = pixelIndex | (regCtrl32bit ? BUFFER_BITS'(3) : BUFFER_BITS'(0));
    succ_addr = (idx_eq == pixelIndexMax) ? BUFFER_BITS'(0)
              : pixelIndex + (regCtrl32bit ? BUFFER_BITS'(4) : BUFFER_BITS'(1));
  end

  // Fetch FSM: one outstanding read, bytes collected in order.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    mode32_d   = mode32_q;
    bytes_d    = bytes_q;
    rd_addr_d  = rd_addr_q;
    rd_req_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!next_valid_q) begin
          state_d    = ST_REQ;
          mode32_d   = regCtrl32bit;
          byte_cnt_d = 2'd0;
          rd_addr_d  = streamOutput ? succ_addr : BUFFER_BITS'(0);
          rd_req_d   = 1'b1;
        end
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rdValid) begin
          bytes_d[byte_cnt_q] = rdData;
          if (!mode32_q || byte_cnt_q == 2'd2) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_REQ;
            byte_cnt_d = byte_cnt_q + 2'd1;
            rd_addr_d  = rd_addr_q + BUFFER_BITS'(1);
            rd_req_d   = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign done_c  = (state_q == ST_DONE);
  assign load_c  = streamOutput && (bitPatternIndex == 3'd0) && (pixelBitIndex == 5'd0);
  assign have_c  = done_c || next_valid_q;
  assign src_c   = done_c ? fetched_c : next_pixel_q;
  assign bit_idx = 5'(5'd23 - pixelBitIndex);

  // Pixel hand-over, bit selection and waveform generation.
  always_comb begin
    next_pixel_d = next_pixel_q;
    next_valid_d = next_valid_q;
    cur_pixel_d  = cur_pixel_q;
    underrun_d   = underrun_q;
    if (done_c) begin
      next_pixel_d = fetched_c;
      next_valid_d = 1'b1;
    end
    if (load_c) begin
      next_valid_d = 1'b0;
      if (have_c) begin
        cur_pixel_d = src_c;
      end else begin
        cur_pixel_d = 24'd0;
        underrun_d  = 1'b1;
      end
    end
    if (load_c)                    bit_c = have_c & src_c[23];
    else if (pixelBitIndex <= 5'd23) bit_c = cur_pixel_q[bit_idx];
    else                           bit_c = 1'b0;
    neo_d = streamOutput && (bitPatternIndex < (bit_c ? 3'd5 : 3'd2));
  end

  always_ff @(posedge clk6_4mhz or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= 2'd0;
      mode32_q     <= 1'b0;
      bytes_q      <= '0;
      next_pixel_q <= 24'd0;
      next_valid_q <= 1'b0;
      cur_pixel_q  <= 24'd0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      neo_q        <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      mode32_q     <= mode32_d;
      bytes_q      <= bytes_d;
      next_pixel_q <= next_pixel_d;
      next_valid_q <= next_valid_d;
      cur_pixel_q  <= cur_pixel_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      neo_q        <= neo_d;
      underrun_q   <= underrun_d;
    end
  end

  assign rdReq       = rd_req_q;
  assign rdAddr      = rd_addr_q;
  assign neopixelOut = neo_q;
  assign underrun    = underrun_q;

`ifdef ANTON_NEOPIXEL_UNDERRUN_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_c && !have_c && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk6_4mhz or negedge rstn) begin
    if (!rstn) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign underrunCount = cnt_q;
`endif

endmodule

// File: tb/tb_anton_neopixel_pixel_shifter.sv
// Scoreboard bench for anton_neopixel_pixel_shifter: expected pulse widths and read addresses are
// queued by the stimulus and consumed by independent monitors.
`timescale 1ns/1ps

module tb_anton_neopixel_pixel_shifter;
  localparam int unsigned BUFFER_END = 63;
  localparam int unsigned BB         = $clog2(BUFFER_END + 1);

  logic          clk6_4mhz = 1'b0;
  logic          rstn;
  logic          streamOutput, streamReset, streamBitOf, streamPixelOf;
  logic          regCtrl32bit;
  logic [2:0]    bitPatternIndex;
  logic [4:0]    pixelBitIndex;
  logic [BB-1:0] pixelIndex, pixelIndexMax;
  logic          rdReq;
  logic [BB-1:0] rdAddr;
  logic [7:0]    rdData;
  logic          rdValid;
  logic          neopixelOut;
  logic          underrun;
`ifdef ANTON_NEOPIXEL_UNDERRUN_COUNT_EN
  logic [7:0]    underrunCount;
`endif

  anton_neopixel_pixel_shifter #(.BUFFER_END(BUFFER_END)) dut (
    .clk6_4mhz      (clk6_4mhz),
    .rstn           (rstn),
    .streamOutput   (streamOutput),
    .streamReset    (streamReset),
    .streamBitOf    (streamBitOf),
    .streamPixelOf  (streamPixelOf),
    .regCtrl32bit   (regCtrl32bit),
    .bitPatternIndex(bitPatternIndex),
    .pixelBitIndex  (pixelBitIndex),
    .pixelIndex     (pixelIndex),
    .pixelIndexMax  (pixelIndexMax),
    .rdReq          (rdReq),
    .rdAddr         (rdAddr),
    .rdData         (rdData),
    .rdValid        (rdValid),
    .neopixelOut    (neopixelOut),
    .underrun       (underrun)
`ifdef ANTON_NEOPIXEL_UNDERRUN_COUNT_EN
    ,
    .underrunCount  (underrunCount)
`endif
  );

  always #5 clk6_4mhz = ~clk6_4mhz;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          hi_cnt = 0;
  int          lat_min = 1;
  int          lat_max = 4;
  bit          mode32 = 1'b1;
  logic [7:0]  mem [64];
  int          exp_w[$];
  int          exp_a[$];
  logic [7:0]  pend_d[$];
  int          pend_t[$];

  always @(posedge clk6_4mhz) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference pixel in GRB order, straight from the buffer contents.
  function automatic logic [23:0] pix_exp(input int p);
    int v, r, g, b;
    if (mode32) return {mem[4*p], mem[4*p+1], mem[4*p+2]};
    v = int'(mem[p]);
    r = v >> 5;
    g = (v >> 2) & 7;
    b = v & 3;
    return 24'(((((g << 5) | (g << 2) | (g >> 1)) & 255) << 16) |
               ((((r << 5) | (r << 2) | (r >> 1)) & 255) << 8) | (b * 8'h55));
  endfunction

  task automatic push_fetch(input int p);
    if (mode32) for (int i = 0; i < 3; i++) exp_a.push_back(4*p + i);
    else exp_a.push_back(p);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk6_4mhz); #1;
      streamOutput = 1'b0; streamReset = 1'b1; streamBitOf = 1'b0; streamPixelOf = 1'b0;
      bitPatternIndex = 3'd0; pixelBitIndex = 5'd0; pixelIndex = '0;
    end
  endtask

  // One frame of npix pixels; pixel 'starve' is expected to find no prefetched data.
  task automatic run_frame(input int npix, input int starve);
    int step;
    logic [23:0] px;
    step = mode32 ? 4 : 1;
    for (int p = 0; p < npix; p++)
      for (int b = 0; b < 24; b++)
        for (int t = 0; t < 8; t++) begin
          @(posedge clk6_4mhz); #1;
          streamOutput = 1'b1; streamReset = 1'b0;
          pixelIndex = BB'(p * step); pixelIndexMax = BB'(npix * step - 1);
          pixelBitIndex = 5'(b); bitPatternIndex = 3'(t);
          streamBitOf = (t == 7); streamPixelOf = (t == 7 && b == 23);
          if (b == 0 && t == 0) begin
            px = (p == starve) ? 24'h0 : pix_exp(p);
            for (int k = 23; k >= 0; k--) exp_w.push_back(px[k] ? 5 : 2);
            if (p != starve) push_fetch((p + 1 == npix) ? 0 : p + 1);
          end
        end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(255, 0));
  endtask

  // Buffer model: in-order returns after a random latency; reset drops anything in flight.
  initial begin
    rdValid = 1'b0; rdData = 8'd0;
    forever begin
      @(posedge clk6_4mhz); #1;
      rdValid = 1'b0;
      if (!rstn) begin
        pend_d.delete(); pend_t.delete();
      end else begin
        if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
          rdValid = 1'b1;
          rdData  = pend_d.pop_front();
          void'(pend_t.pop_front());
        end
        if (rdReq) begin
          pend_d.push_back(mem[rdAddr]);
          pend_t.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        end
      end
    end
  end

  // Read-address monitor.
  initial begin
    forever begin
      @(posedge clk6_4mhz); #1;
      if (rstn && rdReq) begin
        if (exp_a.size() == 0) begin
          checks++; failures++;
          $display("FAIL rdAddr_unexpected actual=%0d expected=none", rdAddr);
        end else check("rdAddr", int'(rdAddr), exp_a.pop_front());
      end
    end
  end

  // Waveform monitor: measures every high pulse on the LED pin.
  initial begin
    forever begin
      @(negedge clk6_4mhz);
      if (!rstn) hi_cnt = 0;
      else if (neopixelOut) hi_cnt++;
      else if (hi_cnt > 0) begin
        if (exp_w.size() == 0) begin
          checks++; failures++;
          $display("FAIL pulse_unexpected actual=%0d expected=none", hi_cnt);
        end else check("pulse_width", hi_cnt, exp_w.pop_front());
        hi_cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; streamOutput = 1'b0; streamReset = 1'b1; streamBitOf = 1'b0; streamPixelOf = 1'b0;
    regCtrl32bit = 1'b1; bitPatternIndex = 3'd0; pixelBitIndex = 5'd0;
    pixelIndex = '0; pixelIndexMax = '0;
    mode32 = 1'b1;
    fill_mem();
    mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'hAA;
    repeat (3) @(posedge clk6_4mhz);
    #1;
    check("reset_rdReq", int'(rdReq), 0);
    check("reset_rdAddr", int'(rdAddr), 0);
    check("reset_neopixelOut", int'(neopixelOut), 0);
    check("reset_underrun", int'(underrun), 0);
`ifdef ANTON_NEOPIXEL_UNDERRUN_COUNT_EN
    check("reset_underrunCount", int'(underrunCount), 0);
`endif

    // 32-bit layout, fixed first frame then random frame lengths.
    push_fetch(0);
    rstn = 1'b1;
    idle(40);
    run_frame(2, -1);
    idle(40);
    run_frame(2, -1);
    for (int f = 0; f < 3; f++) begin
      idle(int'($urandom_range(60, 30)));
      run_frame(int'($urandom_range(4, 2)), -1);
    end
    idle(40);
    check("underrun_32bit", int'(underrun), 0);
    check("addr_queue_drained_32bit", exp_a.size(), 0);

    // 8-bit RGB332 layout.
    @(posedge clk6_4mhz); #1;
    rstn = 1'b0;
    mode32 = 1'b0; regCtrl32bit = 1'b0;
    fill_mem();
    mem[0] = 8'hE3;
    idle(2);
    push_fetch(0);
    rstn = 1'b1;
    idle(40);
    for (int f = 0; f < 3; f++) begin
      run_frame(int'($urandom_range(6, 3)), -1);
      idle(int'($urandom_range(60, 30)));
    end
    check("underrun_8bit", int'(underrun), 0);
    check("addr_queue_drained_8bit", exp_a.size(), 0);

    // Slow buffer: second pixel starves.
    @(posedge clk6_4mhz); #1;
    rstn = 1'b0;
    mode32 = 1'b1; regCtrl32bit = 1'b1;
    lat_min = 200; lat_max = 200;
    fill_mem();
    idle(2);
    push_fetch(0);
    rstn = 1'b1;
    idle(700);
    run_frame(2, 1);
    idle(2);
    check("underrun_set", int'(underrun), 1);
`ifdef ANTON_NEOPIXEL_UNDERRUN_COUNT_EN
    check("underrunCount_one", int'(underrunCount), 1);
`endif
    for (int i = 0; i < 1000 && exp_a.size() != 0; i++) idle(1);
    check("slow_fetch_requests_issued", exp_a.size(), 0);
    idle(10);

    // Reset while a read is outstanding.
    @(posedge clk6_4mhz); #3;
    rstn = 1'b0;
    #1;
    check("async_rst_rdReq", int'(rdReq), 0);
    check("async_rst_rdAddr", int'(rdAddr), 0);
    check("async_rst_neopixelOut", int'(neopixelOut), 0);
    check("async_rst_underrun", int'(underrun), 0);
`ifdef ANTON_NEOPIXEL_UNDERRUN_COUNT_EN
    check("async_rst_underrunCount", int'(underrunCount), 0);
`endif
    lat_min = 1; lat_max = 4;
    idle(2);
    push_fetch(0);
    rstn = 1'b1;
    idle(40);
    run_frame(2, -1);
    idle(40);
    check("underrun_after_reset", int'(underrun), 0);
    check("addr_queue_final", exp_a.size(), 0);
    check("pulse_queue_final", exp_w.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
